// File: rtl/instruction_decode_stage_if.sv
// Handshake and decoded-field bundle between fetch/execute and the decode stage.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface instruction_decode_stage_if #(
    parameter int InstrWidth = 16,
    parameter int OffsetOutW = 16
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [InstrWidth-1:0] in_instr;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0]            out_op;
    logic [5:0]            out_rega;
    logic [5:0]            out_regb;
    logic [OffsetOutW-1:0] out_offset;
    logic                  out_is_alu;
    logic                  out_is_mem;
    logic                  out_is_jump;
    logic                  out_writes_pc;
    logic                  redirect_done;
    logic                  stalled;

    modport slave (
        input  flush, in_valid, in_instr, out_ready, redirect_done,
        output in_ready, out_valid, out_op, out_rega, out_regb, out_offset,
               out_is_alu, out_is_mem, out_is_jump, out_writes_pc, stalled
    );

    modport master (
        output flush, in_valid, in_instr, out_ready, redirect_done,
        input  in_ready, out_valid, out_op, out_rega, out_regb, out_offset,
               out_is_alu, out_is_mem, out_is_jump, out_writes_pc, stalled
    );
endinterface

// File: rtl/instruction_decode_stage.sv
// Decode stage for 16-bit highRisc words: output register plus one-entry skid
// buffer, instruction classification, and an issue stall after any PC redirect
// until execute reports the redirect resolved.
module instruction_decode_stage #(
    parameter int InstrWidth = 16,
    parameter int OffsetOutW = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    instruction_decode_stage_if.slave  bus
);
    // Instruction field layout
    localparam int OpCodeStart = 12;
    localparam int RegAStart   = 6;
    localparam int RegBStart   = 0;
    localparam int OffsetWidth = 9;
    localparam int OpWidth     = 4;
    localparam int RegWidth    = 6;

    localparam logic [OpWidth-1:0]  OP_JR      = 4'd0;
    localparam logic [OpWidth-1:0]  OP_LOAD    = 4'd1;
    localparam logic [OpWidth-1:0]  OP_STORE   = 4'd2;
    localparam logic [RegWidth-1:0] SPECIAL_PC = 6'd63;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    typedef struct packed {
        logic [OpWidth-1:0]    op;
        logic [RegWidth-1:0]   rega;
        logic [RegWidth-1:0]   regb;
        logic [OffsetOutW-1:0] offset;
        logic                  is_alu;
        logic                  is_mem;
        logic                  is_jump;
        logic                  writes_pc;
    } dec_t;

    function automatic dec_t decode_word(input logic [InstrWidth-1:0] w);
        dec_t d;
        d        = '0;
        d.op     = w[OpCodeStart +: OpWidth];
        d.rega   = w[RegAStart +: RegWidth];
        d.regb   = w[RegBStart +: RegWidth];
        d.offset = {{(OffsetOutW-OffsetWidth){w[OffsetWidth-1]}}, w[OffsetWidth-1:0]};
        case (d.op)
            OP_JR:             d.is_jump = 1'b1;
            OP_LOAD, OP_STORE: d.is_mem  = 1'b1;
            default:           d.is_alu  = 1'b1;
        endcase
        // LOAD into PC redirects too; only STORE names PC as a source, not a target
        d.writes_pc = (d.op == OP_JR) ||
                      ((d.op != OP_STORE) && (d.op != OP_JR) && (d.rega == SPECIAL_PC));
        return d;
    endfunction

    logic [0:0]            state_r,     state_s;
    logic                  out_full_r,  out_full_s;
    dec_t                  out_dec_r,   out_dec_s;
    logic                  skid_full_r, skid_full_s;
    logic [InstrWidth-1:0] skid_word_r, skid_word_s;
    logic                  out_valid_r;
    logic                  in_ready_r;
    logic                  stalled_r;
    logic                  in_fire_s;
    logic                  out_fire_s;

    assign in_fire_s  = bus.in_valid && in_ready_r;
    assign out_fire_s = out_valid_r && bus.out_ready;

    // Next-state for the FSM, output register and skid buffer
    always_comb begin
        state_s     = state_r;
        out_full_s  = out_full_r;
        out_dec_s   = out_dec_r;
        skid_full_s = skid_full_r;
        skid_word_s = skid_word_r;
        if (bus.flush) begin
            state_s     = ST_RUN;
            out_full_s  = 1'b0;
            out_dec_s   = '0;
            skid_full_s = 1'b0;
            skid_word_s = '0;
        end else if (state_r == ST_WAIT) begin
            // Everything buffered behind the redirect is wrong-path
            if (bus.redirect_done) begin
                state_s     = ST_RUN;
                out_full_s  = 1'b0;
                out_dec_s   = '0;
                skid_full_s = 1'b0;
                skid_word_s = '0;
            end else begin
                state_s = ST_WAIT;
            end
        end else begin
            if (!out_full_r || out_fire_s) begin
                // in_ready_r is low whenever the skid is full, so no input can
                // arrive in the same cycle the skid refills the output register
                if (skid_full_r) begin
                    out_full_s  = 1'b1;
                    out_dec_s   = decode_word(skid_word_r);
                    skid_full_s = 1'b0;
                end else if (in_fire_s) begin
                    out_full_s = 1'b1;
                    out_dec_s  = decode_word(bus.in_instr);
                end else begin
                    out_full_s = 1'b0;
                end
            end else begin
                if (in_fire_s) begin
                    skid_full_s = 1'b1;
                    skid_word_s = bus.in_instr;
                end else begin
                    skid_full_s = skid_full_r;
                end
            end
            if (out_fire_s && out_dec_r.writes_pc) begin
                state_s = ST_WAIT;
            end else begin
                state_s = ST_RUN;
            end
        end
    end

    // State update; valid/ready/stalled are registered from the next-state view
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            out_full_r  <= 1'b0;
            out_dec_r   <= '0;
            skid_full_r <= 1'b0;
            skid_word_r <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            stalled_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_full_r  <= out_full_s;
            out_dec_r   <= out_dec_s;
            skid_full_r <= skid_full_s;
            skid_word_r <= skid_word_s;
            out_valid_r <= out_full_s && (state_s == ST_RUN);
            in_ready_r  <= !skid_full_s && (state_s == ST_RUN);
            stalled_r   <= (state_s == ST_WAIT);
        end
    end

    assign bus.in_ready      = in_ready_r;
    assign bus.out_valid     = out_valid_r;
    assign bus.out_op        = out_dec_r.op;
    assign bus.out_rega      = out_dec_r.rega;
    assign bus.out_regb      = out_dec_r.regb;
    assign bus.out_offset    = out_dec_r.offset;
    assign bus.out_is_alu    = out_dec_r.is_alu;
    assign bus.out_is_mem    = out_dec_r.is_mem;
    assign bus.out_is_jump   = out_dec_r.is_jump;
    assign bus.out_writes_pc = out_dec_r.writes_pc;
    assign bus.stalled       = stalled_r;
endmodule
